miner_ctrl: RTL

- Host-side controller and the other end of the miner core's interface.
- Assembles the 640-bit work block (header + 32-bit target) from host word writes and launches a sweep by pulsing the miner's reset with a start nonce.
- Masks pipeline warm-up, collects nonce_found/nonce_out results into a FIFO with a valid/ready host handshake, and detects nonce-range exhaustion.

---
 rtl/miner_ctrl_pkg.sv | 37 +++
 rtl/miner_res_fifo.sv | 72 +++++++
 rtl/miner_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/miner_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// miner_ctrl_pkg
// Shared types and constants for the miner host controller.
//   state_t       : controller FSM states
//   WORD_W        : host word width
//   NUM_WORDS     : number of words in a work block
//   BLOCK_W       : work block width (header + target)
//   TARGET_WORD   : word index that holds the 32-bit target (block[31:0])
//   sweep_cycles  : number of RUN cycles needed to cover the whole
//                   32-bit nonce space for a given core stride
// ---------------------------------------------------------------------------
package miner_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    WARM,
    RUN,
    DONE
  } state_t;

  localparam int WORD_W      = 32;
  localparam int NUM_WORDS   = 20;
  localparam int BLOCK_W     = NUM_WORDS * WORD_W;
  localparam int TARGET_WORD = NUM_WORDS - 1;

  // Each RUN cycle the miner advances by `cores` nonces, so covering all
  // 2^32 nonces takes 2^32/cores cycles. Result is wide enough for cores=1.
  function automatic logic [32:0] sweep_cycles(input int cores);
    logic [63:0] total;
    logic [63:0] stride;
    total  = 64'h1_0000_0000;
    stride = 64'(unsigned'(cores));
    return 33'(total / stride);
  endfunction

endpackage

// File: rtl/miner_res_fifo.sv
// ---------------------------------------------------------------------------
// miner_res_fifo
// Synchronous result FIFO for winning nonces.
//   clk      in   clock
//   reset    in   synchronous active-high reset (empties the FIFO)
//   i_flush  in   synchronous flush (empties the FIFO)
//   i_push   in   write request; dropped when full unless a pop happens too
//   i_data   in   write data
//   i_pop    in   read request; ignored when empty
//   o_data   out  head entry (valid only when not empty)
//   o_full   out  all DEPTH entries occupied
//   o_empty  out  no entries
// ---------------------------------------------------------------------------
module miner_res_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic             w_doPush;
  logic             w_doPop;

  // Pointers carry one extra wrap bit: equal pointers mean empty, pointers
  // that differ only in the wrap bit mean full.
  assign o_empty = (r_wrPtr == r_rdPtr);
  assign o_full  = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                   (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);

  // A push into a full FIFO still succeeds when the head leaves in the same
  // cycle, because the slot being written is the one being vacated.
  assign w_doPop  = i_pop & ~o_empty;
  assign w_doPush = i_push & (~o_full | w_doPop);

  assign o_data = r_mem[r_rdPtr[AW-1:0]];

  // Pointer update; flush and reset both empty the queue.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
    end
  end

  // Storage array; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_doPush && !reset && !i_flush) begin
      r_mem[r_wrPtr[AW-1:0]] <= i_data;
    end
  end

endmodule

// File: rtl/miner_ctrl.sv
// ---------------------------------------------------------------------------
// miner_ctrl
// Host-side controller for the miner core. Builds the work block from host
// word writes, launches a nonce sweep by pulsing the miner's reset, masks
// pipeline warm-up, queues hits in a FIFO and flags sweep completion.
//   clk          in   clock
//   reset        in   synchronous active-high reset
//   wr_en        in   shadow block word write strobe
//   wr_addr      in   word index 0..19 (19 = target, higher ignored)
//   wr_data      in   word data
//   start        in   one-cycle launch/relaunch pulse
//   start_nonce  in   first nonce, sampled with start
//   block        out  active work block (bits [31:0] = target)
//   nonce_start  out  registered start nonce
//   miner_reset  out  miner reset, high outside WARM/RUN
//   nonce_found  in   miner hit strobe
//   nonce_out    in   miner hit nonce
//   res_valid    out  result FIFO non-empty
//   res_ready    in   host pop
//   res_nonce    out  result FIFO head
//   res_overflow out  sticky: a hit was dropped
//   busy         out  sweep in progress (RST/WARM/RUN)
//   done         out  sweep complete
// ---------------------------------------------------------------------------
module miner_ctrl
  import miner_ctrl_pkg::*;
#(
  parameter int CORES        = 1,
  parameter int FIFO_DEPTH   = 8,
  parameter int RESET_CYCLES = 2,
  parameter int WARMUP       = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [4:0]   wr_addr,
  input  logic [31:0]  wr_data,
  input  logic         start,
  input  logic [31:0]  start_nonce,
  output logic [639:0] block,
  output logic [31:0]  nonce_start,
  output logic         miner_reset,
  input  logic         nonce_found,
  input  logic [31:0]  nonce_out,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [31:0]  res_nonce,
  output logic         res_overflow,
  output logic         busy,
  output logic         done
);

  localparam logic [32:0] LAST_CNT = sweep_cycles(CORES) - 33'd1;

  state_t             r_state;
  state_t             w_stateNext;
  logic [31:0]        r_phaseCnt;
  logic [32:0]        r_sweepCnt;
  logic [BLOCK_W-1:0] r_shadow;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_drop;

  // Next-state logic. start wins from any state and also cancels a hit that
  // arrives in the same cycle, since the FIFO is being flushed anyway.
  always_comb begin
    w_stateNext = r_state;
    w_push      = 1'b0;
    case (r_state)
      IDLE: ;
      RST: begin
        if (r_phaseCnt == 32'(RESET_CYCLES - 1)) begin
          w_stateNext = WARM;
        end
      end
      WARM: begin
        if (r_phaseCnt == 32'(WARMUP - 1)) begin
          w_stateNext = RUN;
        end
      end
      RUN: begin
        w_push = nonce_found;
        if (r_sweepCnt == LAST_CNT) begin
          w_stateNext = DONE;
        end
      end
      DONE: ;
      default: w_stateNext = IDLE;
    endcase
    if (start) begin
      w_stateNext = RST;
      w_push      = 1'b0;
    end
  end

  assign miner_reset = !((r_state == WARM) || (r_state == RUN));
  assign busy        = (r_state == RST) || (r_state == WARM) || (r_state == RUN);
  assign done        = (r_state == DONE);

  assign w_pop     = res_ready & ~w_empty;
  assign w_drop    = w_push & w_full & ~w_pop;
  assign res_valid = ~w_empty;

  // State register plus the phase counter (RST/WARM length) and the sweep
  // counter (RUN cycles). The phase counter restarts on every state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_phaseCnt <= '0;
      r_sweepCnt <= '0;
    end else begin
      r_state <= w_stateNext;
      if (start || (w_stateNext != r_state)) begin
        r_phaseCnt <= '0;
      end else if ((r_state == RST) || (r_state == WARM)) begin
        r_phaseCnt <= r_phaseCnt + 32'd1;
      end
      if (start) begin
        r_sweepCnt <= '0;
      end else if (r_state == RUN) begin
        r_sweepCnt <= r_sweepCnt + 33'd1;
      end
    end
  end

  // Shadow block, active block and launch registers. The active block copies
  // the shadow as it was before this edge, so a word written in the start
  // cycle only reaches the shadow and waits for the next launch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow     <= '0;
      block        <= '0;
      nonce_start  <= '0;
      res_overflow <= 1'b0;
    end else begin
      for (int k = 0; k <= TARGET_WORD; k++) begin
        if (wr_en && (wr_addr == 5'(k))) begin
          r_shadow[BLOCK_W-1-WORD_W*k -: WORD_W] <= wr_data;
        end
      end
      if (start) begin
        block        <= r_shadow;
        nonce_start  <= start_nonce;
        res_overflow <= 1'b0;
      end else if (w_drop) begin
        res_overflow <= 1'b1;
      end
    end
  end

  miner_res_fifo #(
    .WIDTH(WORD_W),
    .DEPTH(FIFO_DEPTH)
  ) u_resFifo (
    .clk    (clk),
    .reset  (reset),
    .i_flush(start),
    .i_push (w_push),
    .i_data (nonce_out),
    .i_pop  (w_pop),
    .o_data (res_nonce),
    .o_full (w_full),
    .o_empty(w_empty)
  );

endmodule
